// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin sync, clock glitch filter, 11-bit deserializer, E0/F0 folding.
// Optional watchdog compiled in when PS2_RX_TIMEOUT_EN is defined.
module ps2_frame_rx #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_pc2,
    input  logic       data_pc2,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_err,
    output logic       busy
);
    localparam int unsigned FltW = $clog2(FILTER_LEN + 1);
    localparam logic [FltW-1:0] FltLast = FltW'(FILTER_LEN - 1);

    typedef enum logic [1:0] {StIdle, StShift, StParity, StStop} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic [FltW-1:0]        flt_cnt_q;
    logic                   filt_q, filt_prev_q;
    logic [7:0]             sh_q, sh_d, code_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic                   par_q, par_d, ext_q, ext_d, brk_q, brk_d;
    logic                   valid_d, err_d, is_break_d, is_ext_d, busy_d;
    logic                   clk_s, data_s, bit_edge, timeout;

    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign data_s   = data_sync_q[SYNC_STAGES-1];
    assign bit_edge = filt_prev_q & ~filt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            flt_cnt_q   <= '0;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], clk_pc2};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], data_pc2};
            filt_prev_q <= filt_q;
            // Level flips only after FILTER_LEN consecutive differing samples
            if (clk_s != filt_q) begin
                if (flt_cnt_q == FltLast) begin
                    filt_q    <= clk_s;
                    flt_cnt_q <= '0;
                end else begin
                    flt_cnt_q <= flt_cnt_q + 1'b1;
                end
            end else begin
                flt_cnt_q <= '0;
            end
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);
    logic [WdW-1:0] wd_q;

    always_ff @(posedge clk) begin
        if (!rst_n || bit_edge || state_q == StIdle) wd_q <= '0;
        else                                          wd_q <= wd_q + 1'b1;
    end

    // A bit edge in the expiry cycle takes priority and restarts the count
    assign timeout = (state_q != StIdle) && !bit_edge && (wd_q == WdLast);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bit_edge && !data_s) state_d = StShift;
            StShift:  if (bit_edge && bitcnt_q == 3'd7) state_d = StParity;
            StParity: if (bit_edge) state_d = StStop;
            StStop:   if (bit_edge) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (timeout) state_d = StIdle;
    end

    always_comb begin
        sh_d       = sh_q;
        bitcnt_d   = bitcnt_q;
        par_d      = par_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        code_d     = code;
        is_break_d = is_break;
        is_ext_d   = is_extended;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        busy_d     = (state_d != StIdle);
        unique case (state_q)
            StIdle: if (bit_edge && !data_s) bitcnt_d = '0;
            StShift: if (bit_edge) begin
                sh_d     = {data_s, sh_q[7:1]};
                bitcnt_d = bitcnt_q + 1'b1;
            end
            StParity: if (bit_edge) par_d = data_s;
            StStop: if (bit_edge) begin
                if (data_s && (^sh_q ^ par_q)) begin
                    if (sh_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (sh_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else begin
                        code_d     = sh_q;
                        is_break_d = brk_q;
                        is_ext_d   = ext_q;
                        valid_d    = 1'b1;
                        ext_d      = 1'b0;
                        brk_d      = 1'b0;
                    end
                end else begin
                    err_d = 1'b1;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (timeout) begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q        <= '0;
            bitcnt_q    <= '0;
            par_q       <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            code        <= '0;
            code_valid  <= 1'b0;
            is_break    <= 1'b0;
            is_extended <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            bitcnt_q    <= bitcnt_d;
            par_q       <= par_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            code        <= code_d;
            code_valid  <= valid_d;
            is_break    <= is_break_d;
            is_extended <= is_ext_d;
            frame_err   <= err_d;
            busy        <= busy_d;
        end
    end
endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx; watchdog expectations follow PS2_RX_TIMEOUT_EN.
module tb_ps2_frame_rx;
    localparam int unsigned SYNC = 2;
    localparam int unsigned FLT  = 4;
    localparam int unsigned TO   = 200;
    localparam int unsigned HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_pc2 = 1'b1;
    logic       data_pc2 = 1'b1;
    logic [7:0] code;
    logic       code_valid, is_break, is_extended, frame_err, busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int valid_cyc = 0;
    int err_cyc = 0;
    int nvalid = 0;
    int nerr = 0;
    int both_hi = 0;
    int base_v, base_e;

    ps2_frame_rx #(
        .SYNC_STAGES(SYNC),
        .FILTER_LEN(FLT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_pc2(clk_pc2),
        .data_pc2(data_pc2),
        .code(code),
        .code_valid(code_valid),
        .is_break(is_break),
        .is_extended(is_extended),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (code_valid) begin nvalid++; valid_cyc = cyc; end
        if (frame_err) begin nerr++; err_cyc = cyc; end
        if (code_valid && frame_err) both_hi++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        @(posedge clk); #1 data_pc2 = b;
        if (glitch) begin
            repeat (8) @(posedge clk);
            #1 clk_pc2 = 1'b0;
            repeat (FLT - 1) @(posedge clk);
            #1 clk_pc2 = 1'b1;
            repeat (HALF - 8 - (FLT - 1)) @(posedge clk);
        end else begin
            repeat (HALF) @(posedge clk);
        end
        #1 clk_pc2 = 1'b0;
        fall_cyc = cyc;
        repeat (HALF) @(posedge clk);
        #1 clk_pc2 = 1'b1;
    endtask

    // nbits limits how many of the 11 frame bits are sent; glitch_bit = -1 for none
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                              input int glitch_bit);
        logic [10:0] f;
        f = {1'b1, ~^b ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], i == glitch_bit);
        @(posedge clk); #1 data_pc2 = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic mark;
        base_v = nvalid;
        base_e = nerr;
    endtask

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_code", code, 8'h00);
        check("rst_valid", code_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {is_break, is_extended}, 2'b00);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);

        mark(); send_frame(8'h1C, 0, 11, -1);
        check("1c_nvalid", nvalid - base_v, 1);
        check("1c_nerr", nerr - base_e, 0);
        check("1c_code", code, 8'h1C);
        check("1c_flags", {is_break, is_extended}, 2'b00);
        check("1c_latency", valid_cyc - fall_cyc, SYNC + FLT + 1);
        check("1c_busy", busy, 0);

        mark(); send_frame(8'hF0, 0, 11, -1);
        check("f0_nostrobe", nvalid - base_v, 0);
        send_frame(8'h1C, 0, 11, -1);
        check("brk_nvalid", nvalid - base_v, 1);
        check("brk_code", code, 8'h1C);
        check("brk_flags", {is_break, is_extended}, 2'b10);
        mark(); send_frame(8'h1C, 0, 11, -1);
        check("brk_clear", {is_break, is_extended}, 2'b00);

        mark(); send_frame(8'hE0, 0, 11, -1);
        send_frame(8'hF0, 0, 11, -1);
        send_frame(8'h75, 0, 11, -1);
        check("ext_nvalid", nvalid - base_v, 1);
        check("ext_code", code, 8'h75);
        check("ext_flags", {is_break, is_extended}, 2'b11);

        mark(); send_frame(8'h1C, 1, 11, -1);
        check("par_nerr", nerr - base_e, 1);
        check("par_nvalid", nvalid - base_v, 0);
        check("par_code_held", code, 8'h75);
        mark(); send_frame(8'h32, 0, 11, -1);
        check("32_code", code, 8'h32);
        check("32_nvalid", nvalid - base_v, 1);
        check("32_nerr", nerr - base_e, 0);

        mark(); send_frame(8'h5A, 0, 11, 4);
        check("glitch_code", code, 8'h5A);
        check("glitch_nvalid", nvalid - base_v, 1);
        check("glitch_nerr", nerr - base_e, 0);

        for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_busy", busy, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_code", code, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1; data_pc2 = 1'b1;
        repeat (10) @(posedge clk);
        mark(); send_frame(8'h1C, 0, 11, -1);
        check("post_rst_code", code, 8'h1C);
        check("post_rst_nvalid", nvalid - base_v, 1);

        // Start bit plus three data bits, then the pin goes quiet
        mark();
        for (int i = 0; i < 4; i++) send_bit(1'b0, 0);
        for (int i = 0; i < int'(TO) + 100; i++) begin
            @(negedge clk);
            if (nerr != base_e) break;
        end
`ifdef PS2_RX_TIMEOUT_EN
        check("to_nerr", nerr - base_e, 1);
        check("to_delay", err_cyc - fall_cyc, SYNC + FLT + 1 + TO);
        check("to_busy", busy, 0);
`else
        check("to_nerr", nerr - base_e, 0);
        check("to_busy", busy, 1);
`endif
        check("to_nvalid", nvalid - base_v, 0);
        check("no_overlap", both_hi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
